mac_dot_engine: RTL and testbench

- Pipelined, parametrised multiply-accumulate engine for the matrix accelerator.
- Computes one dot product per vector: the sum of a[i]*b[i] over len beats.
- Accepts operands over a valid/ready stream and holds the result until the consumer takes it.
- Supports synchronous clear, saturating or wrapping accumulation, and a sticky overflow flag.

---
 rtl/mac_dot_engine.sv | 139 +++++++++++++
 tb/tb_mac_dot_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_engine.sv
// Pipelined unsigned multiply-accumulate dot-product engine with a valid/ready operand stream,
// a held result, synchronous clear, and saturating or wrapping accumulation.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for the first beat of a vector
//   ACCUM | accepting the remaining beats of the vector
//   WAIT  | last beat accepted; draining the product stage into acc
//   DONE  | result presented on out_data/out_ovf until the consumer takes it

module mac_dot_engine #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int LEN_W    = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0]    acc;
    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    len_sel;
    logic [LEN_W-1:0]    len_eff;
    logic [2*DATA_W-1:0] prod_q;
    logic                prod_v;
    logic                prod_last;
    logic                ovf;
    logic                accept;
    logic                is_last;
    logic                out_fire;
    logic [ACC_W:0]      sum;

    // The first beat uses the live len input; later beats use the latched copy.
    assign len_sel  = (state == IDLE) ? len : len_q;
    assign len_eff  = (len_sel == '0) ? LEN_W'(1) : len_sel;
    assign accept   = in_valid && in_ready;
    assign is_last  = accept && (cnt == (len_eff - LEN_W'(1)));
    assign out_fire = (state == DONE) && out_ready;
    assign sum      = {1'b0, acc} + {{(ACC_W + 1 - 2*DATA_W){1'b0}}, prod_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = is_last ? WAIT : ACCUM;
                ACCUM:   if (is_last) state_nxt = WAIT;
                WAIT:    if (prod_v && prod_last) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = rst_n && !clear && ((state == IDLE) || (state == ACCUM));
        out_valid = (state == DONE);
        out_data  = (state == DONE) ? acc : '0;
        out_ovf   = (state == DONE) ? ovf : 1'b0;
        busy      = (state != IDLE) || prod_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= is_last ? '0 : cnt + LEN_W'(1);
            if (state == IDLE) len_q <= len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q    <= '0;
            prod_v    <= 1'b0;
            prod_last <= 1'b0;
        end else if (clear) begin
            prod_v    <= 1'b0;
            prod_last <= 1'b0;
        end else begin
            if (accept) prod_q <= a * b;
            prod_v    <= accept;
            prod_last <= is_last;
        end
    end

    // Saturation clamps to all-ones, so a saturated acc stays all-ones on every later add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear || out_fire) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (prod_v) begin
            if (sum[ACC_W]) begin
                ovf <= 1'b1;
                acc <= SATURATE ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            end else begin
                acc <= sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_engine.sv
// Bench for mac_dot_engine: a saturating and a wrapping instance share one stimulus stream
// and are compared against an arithmetic dot-product model.

module tb_mac_dot_engine;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [LW-1:0] len = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          out_ready = 1'b0;

    logic          in_ready_s, out_valid_s, out_ovf_s, busy_s;
    logic          in_ready_w, out_valid_w, out_ovf_w, busy_w;
    logic [AW-1:0] out_data_s, out_data_w;

    int n_chk = 0;
    int n_fail = 0;
    int va [16];
    int vb [16];

    mac_dot_engine #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_ovf(out_ovf_s), .busy(busy_s)
    );

    mac_dot_engine #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .clear(clear), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .out_ovf(out_ovf_w), .busy(busy_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Dot product of the first n beats, checking the true sum against the 2^AW range per add.
    function automatic void model(input int n, input bit sat, output longint res, output bit ovf);
        res = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            res = res + longint'(va[i]) * longint'(vb[i]);
            if (res >= (longint'(1) << AW)) begin
                ovf = 1'b1;
                res = sat ? (longint'(1) << AW) - 1 : res - (longint'(1) << AW);
            end
        end
    endfunction

    // gap < 0 picks a random 0..3 idle cycles between beats.
    task automatic send_vec(input int ln, input int gap);
        int n;
        int g;
        n = (ln == 0) ? 1 : ln;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            len = (i == 0) ? LW'(ln) : LW'($urandom);
            a = DW'(va[i]);
            b = DW'(vb[i]);
            chk("in_ready_beat", {in_ready_s, in_ready_w}, 2'b11);
            step();
            in_valid = 1'b0;
            a = DW'($urandom);
            b = DW'($urandom);
            if (i < n - 1) begin
                g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
                for (int k = 0; k < g; k++) begin
                    chk("gap_no_valid", {out_valid_s, out_valid_w}, 2'b00);
                    step();
                end
            end
        end
        chk("valid_after_1", {out_valid_s, out_valid_w}, 2'b00);
        step();
        chk("valid_after_2", {out_valid_s, out_valid_w}, 2'b11);
    endtask

    task automatic take_result(input int ln, input int hold);
        longint rs, rw;
        bit os, ow;
        int n;
        n = (ln == 0) ? 1 : ln;
        model(n, 1'b1, rs, os);
        model(n, 1'b0, rw, ow);
        chk("data_sat", out_data_s, rs);
        chk("ovf_sat", out_ovf_s, os);
        chk("data_wrap", out_data_w, rw);
        chk("ovf_wrap", out_ovf_w, ow);
        for (int k = 0; k < hold; k++) begin
            step();
            chk("hold_valid", {out_valid_s, out_valid_w}, 2'b11);
            chk("hold_data_sat", out_data_s, rs);
            chk("hold_data_wrap", out_data_w, rw);
            chk("hold_in_ready", {in_ready_s, in_ready_w}, 2'b00);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_valid", {out_valid_s, out_valid_w}, 2'b00);
        chk("post_in_ready", {in_ready_s, in_ready_w}, 2'b11);
        chk("post_busy", {busy_s, busy_w}, 2'b00);
    endtask

    task automatic run_vec(input int ln, input int gap, input int hold);
        out_ready = (hold == 0);
        send_vec(ln, gap);
        take_result(ln, hold);
    endtask

    initial begin
        step();
        chk("rst_in_ready", {in_ready_s, in_ready_w}, 2'b00);
        chk("rst_valid", {out_valid_s, out_valid_w}, 2'b00);
        chk("rst_data", {out_data_s, out_data_w}, 0);
        chk("rst_ovf_busy", {out_ovf_s, out_ovf_w, busy_s, busy_w}, 0);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", {in_ready_s, in_ready_w}, 2'b11);

        va[0] = 2; vb[0] = 3; va[1] = 4; vb[1] = 5; va[2] = 6; vb[2] = 7;
        run_vec(3, 0, 0);

        va[0] = 255; vb[0] = 255; va[1] = 255; vb[1] = 255;
        run_vec(2, 0, 0);

        va[0] = 10; vb[0] = 10; va[1] = 1; vb[1] = 1;
        run_vec(2, 0, 5);
        va[0] = 3; vb[0] = 4;
        run_vec(1, 0, 0);

        // Abort a len=4 vector after two beats; the beat offered alongside clear must be dropped.
        va[0] = 9; vb[0] = 9; va[1] = 8; vb[1] = 8;
        len = 4'd4;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a = DW'(va[i]);
            b = DW'(vb[i]);
            step();
        end
        clear = 1'b1;
        a = 8'd50;
        b = 8'd50;
        #1;
        chk("clear_in_ready", {in_ready_s, in_ready_w}, 2'b00);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear_busy", {busy_s, busy_w}, 2'b00);
        for (int k = 0; k < 3; k++) begin
            chk("clear_no_valid", {out_valid_s, out_valid_w}, 2'b00);
            step();
        end
        va[0] = 10; vb[0] = 10;
        run_vec(1, 0, 0);

        va[0] = 3; vb[0] = 3;
        run_vec(0, 0, 0);
        va[0] = 5; vb[0] = 6; va[1] = 7; vb[1] = 8; va[2] = 9; vb[2] = 10;
        run_vec(3, 3, 1);

        // Reset while the engine waits on its last product.
        len = 4'd1;
        in_valid = 1'b1;
        a = 8'd7;
        b = 8'd7;
        step();
        in_valid = 1'b0;
        chk("wait_busy", {busy_s, busy_w}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {out_valid_s, out_valid_w}, 2'b00);
        chk("mid_rst_data", {out_data_s, out_data_w}, 0);
        chk("mid_rst_busy", {busy_s, busy_w}, 2'b00);
        chk("mid_rst_in_ready", {in_ready_s, in_ready_w}, 2'b00);
        step();
        step();
        rst_n = 1'b1;
        step();
        va[0] = 1; vb[0] = 1;
        run_vec(1, 0, 0);

        for (int v = 0; v < 25; v++) begin
            int ln;
            ln = int'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) begin
                va[i] = (v % 4 == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 255));
                vb[i] = (v % 4 == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 255));
            end
            run_vec(ln, -1, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
